// File: rtl/uart_tx_model.sv
// uart_tx_model: FIFO-buffered UART transmitter.
// Baud rate is given in reference-clock cycles. Frame format is sampled when
// each word is popped, so control changes take effect on the next frame.
module uart_tx_model #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic signed [31:0] ctrl_baud_clks_i,
   input  logic signed [31:0] ctrl_bits_i,
   input  logic signed [31:0] ctrl_stops_i,
   input  logic               tx_valid_i,
   input  logic        [31:0] tx_data_i,
   output logic               tx_rdy_o,
   output logic               txd_o,
   output logic               tx_busy_o,
   output logic               tx_done_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} state_e;

   logic [31:0]   mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   state_e        state_q;
   logic [31:0]   shreg_q;
   logic [31:0]   baud_q, bits_q, stops_q;
   logic [31:0]   bcnt_q, bitcnt_q;
   logic          txd_q, done_q;

   logic [31:0]   baud_cl, bits_cl, stops_cl;
   logic          push, pop, baud_end, stop_end;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Clamp the runtime frame controls to their legal ranges.
   always_comb begin
      baud_cl  = (ctrl_baud_clks_i < 32'sd1) ? 32'd1 : 32'(ctrl_baud_clks_i);
      stops_cl = (ctrl_stops_i < 32'sd1) ? 32'd1 : 32'(ctrl_stops_i);
      bits_cl  = 32'd1;
      if (ctrl_bits_i > 32'sd32)      bits_cl = 32'd32;
      else if (ctrl_bits_i >= 32'sd1) bits_cl = 32'(ctrl_bits_i);
   end

   assign tx_rdy_o  = !rst_i && (count_q < CW'(FIFO_DEPTH));
   assign push      = tx_valid_i && tx_rdy_o;
   assign baud_end  = (bcnt_q >= baud_q);
   assign stop_end  = (state_q == TX_STOP) && baud_end && (bitcnt_q >= stops_q);
   // Pop either from idle or at the end of the last stop bit, so queued
   // frames go out back to back.
   assign pop       = (count_q != '0) && ((state_q == TX_IDLE) || stop_end);

   assign txd_o     = txd_q;
   assign tx_done_o = done_q;
   assign tx_busy_o = (state_q != TX_IDLE) || (count_q != '0);

   // FIFO next-state pointers and occupancy.
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   // FIFO storage; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk_i)
      if (push) mem_q[wr_ptr_q] <= tx_data_i;

   // FIFO pointer and count registers.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end

   // Frame FSM; txd is registered from the current state, so the line
   // follows the state by one cycle.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q  <= TX_IDLE;
         shreg_q  <= '0;
         baud_q   <= 32'd1;
         bits_q   <= 32'd1;
         stops_q  <= 32'd1;
         bcnt_q   <= 32'd1;
         bitcnt_q <= 32'd1;
         txd_q    <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         done_q <= stop_end;
         case (state_q)
            TX_IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shreg_q <= mem_q[rd_ptr_q];
                  baud_q  <= baud_cl;
                  bits_q  <= bits_cl;
                  stops_q <= stops_cl;
                  bcnt_q  <= 32'd1;
                  state_q <= TX_START;
               end
            end
            TX_START: begin
               txd_q <= 1'b0;
               if (baud_end) begin
                  bcnt_q   <= 32'd1;
                  bitcnt_q <= 32'd1;
                  state_q  <= TX_DATA;
               end else bcnt_q <= bcnt_q + 32'd1;
            end
            TX_DATA: begin
               txd_q <= shreg_q[0];
               if (baud_end) begin
                  bcnt_q  <= 32'd1;
                  shreg_q <= shreg_q >> 1;
                  if (bitcnt_q >= bits_q) begin
                     bitcnt_q <= 32'd1;
                     state_q  <= TX_STOP;
                  end else bitcnt_q <= bitcnt_q + 32'd1;
               end else bcnt_q <= bcnt_q + 32'd1;
            end
            TX_STOP: begin
               txd_q <= 1'b1;
               if (baud_end) begin
                  bcnt_q <= 32'd1;
                  if (bitcnt_q >= stops_q) begin
                     if (pop) begin
                        shreg_q <= mem_q[rd_ptr_q];
                        baud_q  <= baud_cl;
                        bits_q  <= bits_cl;
                        stops_q <= stops_cl;
                        state_q <= TX_START;
                     end else state_q <= TX_IDLE;
                  end else bitcnt_q <= bitcnt_q + 32'd1;
               end else bcnt_q <= bcnt_q + 32'd1;
            end
            default: state_q <= TX_IDLE;
         endcase
      end

endmodule

// File: tb/tb_uart_tx_model.sv
// Bench for uart_tx_model: a frame-level reference model (queue plus a
// position counter within the current frame) is compared against the DUT on
// every cycle, and directed scenarios pin the model with literal timings.
module tb_uart_tx_model;

   localparam int DEPTH = 4;
   localparam int NC    = 20000;

   logic        clk = 1'b0;
   logic        rst;
   int          ctrl_baud, ctrl_bits, ctrl_stops;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_rdy, txd, tx_busy, tx_done;

   uart_tx_model #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .ctrl_baud_clks_i(ctrl_baud), .ctrl_bits_i(ctrl_bits), .ctrl_stops_i(ctrl_stops),
      .tx_valid_i(tx_valid), .tx_data_i(tx_data),
      .tx_rdy_o(tx_rdy), .txd_o(txd), .tx_busy_o(tx_busy), .tx_done_o(tx_done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   bit txd_h [NC], done_h [NC], busy_h [NC];

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] mq [$];
   bit          m_act;
   int          m_pos, m_len, m_baud, m_bits, m_stops;
   logic [31:0] m_word;
   bit          m_txd, m_done;

   function automatic int clamp_lo(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   // Line level at frame position m_pos: start, data LSB first, then stops.
   function automatic bit line_at();
      int idx;
      idx = m_pos / m_baud;
      if (idx == 0) return 1'b0;
      if (idx <= m_bits) return m_word[idx-1];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      bit can_push;
      cyc++;
      if (rst) begin
         mq.delete();
         m_act = 0; m_txd = 1; m_done = 0; m_pos = 0;
      end else begin
         can_push = tx_valid && (mq.size() < DEPTH);
         m_txd    = m_act ? line_at() : 1'b1;
         m_done   = 0;
         if (m_act) begin
            m_pos++;
            if (m_pos == m_len) begin m_done = 1; m_act = 0; end
         end
         if (!m_act && mq.size() > 0) begin
            m_word  = mq.pop_front();
            m_baud  = clamp_lo(ctrl_baud);
            m_bits  = (ctrl_bits > 32) ? 32 : clamp_lo(ctrl_bits);
            m_stops = clamp_lo(ctrl_stops);
            m_len   = (1 + m_bits + m_stops) * m_baud;
            m_pos   = 0;
            m_act   = 1;
         end
         if (can_push) mq.push_back(tx_data);
      end
   end

   // Per-cycle compare and history capture, away from the active edge.
   always @(posedge clk) begin
      #1;
      if (cyc < NC) begin
         txd_h[cyc]  = txd;
         done_h[cyc] = tx_done;
         busy_h[cyc] = tx_busy;
      end
      chk("txd", txd, m_txd);
      chk("tx_done", tx_done, m_done);
      chk("tx_busy", tx_busy, m_act || (mq.size() != 0));
      chk("tx_rdy", tx_rdy, !rst && (mq.size() < DEPTH));
   end

   // ---------------- stimulus helpers ----------------
   // Called just after a falling edge; returns the number of the accepting edge.
   task automatic push(input logic [31:0] d, output int acc);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      while (!tx_rdy && n < 2000) begin @(negedge clk); n++; end
      chk("push_timeout", n < 2000, 1);
      acc = cyc + 1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((tx_busy || !txd) && n < 5000) begin @(negedge clk); n++; end
      chk("idle_timeout", n < 5000, 1);
      repeat (2) @(negedge clk);
   endtask

   function automatic int find_done(input int from);
      for (int i = from; i <= cyc && i < NC; i++) if (done_h[i]) return i;
      return -1;
   endfunction

   function automatic int count_done(input int from, input int to);
      int c = 0;
      for (int i = from; i <= to && i < NC; i++) if (done_h[i]) c++;
      return c;
   endfunction

   // 10 line samples, one per bit period, starting at the start bit.
   function automatic logic [9:0] frame_bits(input int first, input int baud);
      logic [9:0] v;
      for (int i = 0; i < 10; i++) v[i] = txd_h[first + baud*i];
      return v;
   endfunction

   // ---------------- scenarios ----------------
   initial begin
      int a1, a2, a3, a6, d1, d2, r0, zeros, allhi, prev;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
      ctrl_baud = 4; ctrl_bits = 8; ctrl_stops = 1;
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_rdy", tx_rdy, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      rst = 1'b0;
      #1 chk("rdy_after_rst", tx_rdy, 1);
      @(negedge clk);

      // Single byte 0xA5, baud 4.
      push(32'hA5, a1);
      wait_idle();
      chk("a5_idle_before", txd_h[a1+1], 1);
      chk("a5_frame", frame_bits(a1 + 2, 4), 10'h34A);
      chk("a5_start_end", txd_h[a1+5], 0);
      d1 = find_done(a1);
      chk("a5_done_lat", d1 - a1, 41);
      chk("a5_busy_drop", {busy_h[d1-1], busy_h[d1]}, 2'b10);
      chk("a5_done_cnt", count_done(a1, cyc), 1);

      // FIFO full and back to back, baud 2.
      ctrl_baud = 2;
      push(32'h01, a1);
      push(32'h02, a2);
      push(32'h03, a2);
      push(32'h04, a2);
      push(32'h05, a2);
      chk("full_rdy", tx_rdy, 0);
      push(32'h06, a6);
      chk("stall_accept", a6 - a1, 22);
      wait_idle();
      chk("b2b_done_cnt", count_done(a1, cyc), 6);
      prev = find_done(a1);
      for (int i = 0; i < 5; i++) begin
         d2 = find_done(prev + 1);
         chk("b2b_spacing", d2 - prev, 20);
         prev = d2;
      end

      // 5 data bits, 2 stops, baud 3, data 0xFF.
      ctrl_baud = 3; ctrl_bits = 5; ctrl_stops = 2;
      push(32'hFF, a1);
      wait_idle();
      chk("fmt5_done_lat", find_done(a1) - a1, 25);
      zeros = 0;
      for (int i = a1 + 1; i <= cyc; i++) zeros += (txd_h[i] == 1'b0) ? 1 : 0;
      chk("fmt5_zero_cycles", zeros, 3);

      // bits=40 clamps to 32.
      ctrl_baud = 1; ctrl_bits = 40; ctrl_stops = 1;
      push(32'hFFFF_FFFF, a1);
      wait_idle();
      chk("bits40_done_lat", find_done(a1) - a1, 35);

      // Mid-frame baud change.
      ctrl_baud = 4; ctrl_bits = 8; ctrl_stops = 1;
      push(32'h55, a1);
      push(32'hC3, a2);
      repeat (10) @(negedge clk);
      ctrl_baud = 8;
      wait_idle();
      d1 = find_done(a1);
      d2 = find_done(d1 + 1);
      chk("chg_frame1", frame_bits(a1 + 2, 4), 10'h2AA);
      chk("chg_done1", d1 - a1, 41);
      chk("chg_done2", d2 - d1, 80);

      // Reset during TX_DATA with words queued.
      ctrl_baud = 4;
      push(32'h12, a1);
      push(32'h34, a2);
      push(32'h56, a2);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_txd", txd, 1);
      chk("mrst_busy", tx_busy, 0);
      chk("mrst_rdy", tx_rdy, 0);
      chk("mrst_done", tx_done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r0 = cyc;
      repeat (60) @(negedge clk);
      allhi = 1;
      for (int i = r0 + 1; i <= cyc; i++) if (!txd_h[i]) allhi = 0;
      chk("mrst_line_idle", allhi, 1);
      chk("mrst_no_done", count_done(r0 - 3, cyc), 0);
      chk("mrst_rdy_after", tx_rdy, 1);

      // Push on the same edge as the pop at the end of a stop bit.
      ctrl_baud = 2;
      push(32'h11, a1);
      push(32'h22, a2);
      while (cyc < a1 + 20) @(negedge clk);
      push(32'h33, a3);
      chk("pp_accept_edge", a3 - a1, 21);
      chk("pp_done_edge", done_h[a3], 1);
      chk("pp_count", dut.count_q, 1);
      wait_idle();
      chk("pp_done_cnt", count_done(a1, cyc), 3);

      // Randomized traffic with control changes at arbitrary times.
      for (int i = 0; i < 400; i++) begin
         tx_valid = 1'($urandom_range(0, 1));
         tx_data  = $urandom;
         if ($urandom_range(0, 7) == 0) begin
            ctrl_baud  = int'($urandom_range(0, 5)) - 1;
            ctrl_bits  = int'($urandom_range(0, 42)) - 2;
            ctrl_stops = int'($urandom_range(0, 4)) - 1;
         end
         @(negedge clk);
      end
      tx_valid = 1'b0;
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
